// File: rtl/tag_fifo.sv
// tag_fifo: circular free-tag pool, pre-filled with every tag at reset, popped by dispatch and refilled by CDB returns
module tag_fifo #(
    parameter int TAG_W = 6,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pop_tag,
    output logic [TAG_W-1:0] tag_out,
    output logic             tag_valid,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    output logic             full,
    output logic [TAG_W:0]   count,
    output logic             overflow_err,
    output logic             underflow_err
);
    logic [TAG_W-1:0] mem [DEPTH];
    logic [TAG_W:0]   rd_ptr, wr_ptr;
    logic             do_push, do_pop;

    // status derived from the wrap-bit pointers; push/pop qualified by pre-edge state
    always_comb begin
        count     = wr_ptr - rd_ptr;
        tag_valid = rd_ptr != wr_ptr;
        full      = (rd_ptr[TAG_W-1:0] == wr_ptr[TAG_W-1:0]) && (rd_ptr[TAG_W] != wr_ptr[TAG_W]);
        tag_out   = mem[rd_ptr[TAG_W-1:0]];
        do_push   = cdb_valid && !full;
        do_pop    = pop_tag && tag_valid;
    end

    // pointers and sticky error flags; reset leaves the pool holding every tag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr        <= '0;
            wr_ptr        <= (TAG_W+1)'(DEPTH);
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            rd_ptr        <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
            wr_ptr        <= do_push ? wr_ptr + 1'b1 : wr_ptr;
            overflow_err  <= overflow_err || (cdb_valid && full);
            underflow_err <= underflow_err || (pop_tag && !tag_valid);
        end
    end

    // tag storage, reloaded with the identity sequence 0..DEPTH-1 on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= TAG_W'(i);
        end else if (do_push) begin
            mem[wr_ptr[TAG_W-1:0]] <= cdb_tag;
        end
    end
endmodule

// File: tb/tb_tag_fifo.sv
// tb_tag_fifo: directed tests of tag_fifo against a queue model plus hand-computed expectations
module tb_tag_fifo;
    localparam int TW = 6;
    localparam int D  = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          pop_tag = 1'b0;
    logic          cdb_valid = 1'b0;
    logic [TW-1:0] cdb_tag = '0;
    logic [TW-1:0] tag_out;
    logic          tag_valid;
    logic          full;
    logic [TW:0]   count;
    logic          overflow_err;
    logic          underflow_err;

    int total = 0;
    int bad   = 0;
    int q[$];
    bit m_ovf, m_unf;

    tag_fifo #(.TAG_W(TW), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .pop_tag(pop_tag), .tag_out(tag_out), .tag_valid(tag_valid),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .full(full), .count(count),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < D; i++) q.push_back(i);
        m_ovf = 0;
        m_unf = 0;
    endtask

    // free pool as a plain queue: pop takes the oldest, push appends, both judged on the size before the edge
    task automatic model_upd();
        int n;
        n = q.size();
        if (pop_tag) begin
            if (n == 0) m_unf = 1;
            else void'(q.pop_front());
        end
        if (cdb_valid) begin
            if (n == D) m_ovf = 1;
            else q.push_back(int'(cdb_tag));
        end
    endtask

    task automatic step(bit p, bit c, int t);
        pop_tag   = p;
        cdb_valid = c;
        cdb_tag   = TW'(t);
        @(posedge clk);
        model_upd();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        pop_tag = 1'b0;
        cdb_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("count", int'(count), q.size());
            chk("full", int'(full), int'(q.size() == D));
            chk("tag_valid", int'(tag_valid), int'(q.size() != 0));
            if (q.size() != 0) chk("tag_out", int'(tag_out), q[0]);
            chk("overflow_err", int'(overflow_err), int'(m_ovf));
            chk("underflow_err", int'(underflow_err), int'(m_unf));
        end
    end

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        chk("rst_count", int'(count), 64);
        chk("rst_full", int'(full), 1);
        chk("rst_tag_out", int'(tag_out), 0);
        chk("rst_valid", int'(tag_valid), 1);
        chk("rst_ovf", int'(overflow_err), 0);
        chk("rst_unf", int'(underflow_err), 0);

        for (int i = 0; i < 3; i++) begin
            chk("pop_head", int'(tag_out), i);
            step(1, 0, 0);
        end
        chk("pop3_tag_out", int'(tag_out), 3);
        chk("pop3_count", int'(count), 61);
        chk("pop3_full", int'(full), 0);

        for (int i = 3; i < D; i++) begin
            chk("drain_head", int'(tag_out), i);
            step(1, 0, 0);
        end
        chk("empty_valid", int'(tag_valid), 0);
        chk("empty_count", int'(count), 0);
        chk("empty_unf_clear", int'(underflow_err), 0);
        step(1, 0, 0);
        chk("extra_pop_unf", int'(underflow_err), 1);
        chk("extra_pop_rd_ptr", int'(dut.rd_ptr), 64);
        chk("extra_pop_count", int'(count), 0);

        step(1, 1, 5);
        chk("empty_push_tag_out", int'(tag_out), 5);
        chk("empty_push_count", int'(count), 1);
        chk("empty_push_valid", int'(tag_valid), 1);
        chk("empty_push_unf", int'(underflow_err), 1);

        do_reset();
        step(1, 0, 0);
        for (int k = 0; k < 128; k++) begin
            step(1, 1, k % 64);
            if (k == 0) begin
                chk("swap1_count", int'(count), 63);
                chk("swap1_tag_out", int'(tag_out), 2);
            end
        end
        chk("wrap_count", int'(count), 63);
        chk("wrap_tag_out", int'(tag_out), 1);
        chk("wrap_rd_ptr", int'(dut.rd_ptr), 1);
        chk("wrap_wr_ptr", int'(dut.wr_ptr), 64);

        do_reset();
        step(0, 1, 9);
        chk("full_push_ovf", int'(overflow_err), 1);
        chk("full_push_count", int'(count), 64);
        chk("full_push_tag_out", int'(tag_out), 0);
        step(1, 1, 9);
        chk("full_swap_count", int'(count), 63);
        chk("full_swap_tag_out", int'(tag_out), 1);
        chk("full_swap_ovf", int'(overflow_err), 1);

        pop_tag   = 1'b1;
        cdb_valid = 1'b1;
        cdb_tag   = 6'd7;
        @(posedge clk);
        model_upd();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("async_count", int'(count), 64);
        chk("async_full", int'(full), 1);
        chk("async_tag_out", int'(tag_out), 0);
        chk("async_valid", int'(tag_valid), 1);
        chk("async_ovf", int'(overflow_err), 0);
        chk("async_unf", int'(underflow_err), 0);
        @(negedge clk);
        pop_tag   = 1'b0;
        cdb_valid = 1'b0;
        rst = 1'b1;
        step(0, 0, 0);
        step(1, 0, 0);
        chk("post_reset_tag_out", int'(tag_out), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
